// File: rtl/ntt_stage_ctrl.sv
// Control FSM for one single-delay-feedback NTT stage: sequences the feedback FIFO,
// butterfly muxes, twiddle addressing and multiplier-valid pipeline over one frame.
module ntt_stage_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BLOCKS     = 2,
    parameter int unsigned TW_DEPTH   = 8,
    parameter int unsigned TW_STEP    = 1,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        tw_ready,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        push,
    output logic                        pop,
    output logic                        sel1,
    output logic                        sel2,
    output logic [$clog2(TW_DEPTH)-1:0] tw_addr,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  state
);

    localparam int unsigned TW_AW = $clog2(TW_DEPTH);
    localparam int unsigned PH_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BLK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(FIFO_DEPTH - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BFLY  = 3'd2,
        S_DRAIN = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [TW_AW-1:0]   tw_q, tw_d;
    logic [TW_AW-1:0]   tw_next;
    logic [31:0]        tw_sum;
    logic               issue;
    logic [MUL_LAT-1:0] sr_q;

    // Twiddle address wraps modulo TW_DEPTH, which need not be a power of two.
    assign tw_sum  = 32'(tw_q) + TW_STEP;
    assign tw_next = TW_AW'(tw_sum % TW_DEPTH);

    assign state     = state_q;
    assign tw_addr   = tw_q;
    assign out_valid = sr_q[MUL_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            blk_q   <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
            tw_q    <= tw_d;
        end
    end

    // Next-state and strobe decode; a missing in_valid freezes everything in the streaming states.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        blk_d    = blk_q;
        tw_d     = tw_q;
        in_ready = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && tw_ready) begin
                    state_d = S_FILL;
                    phase_d = '0;
                    blk_d   = '0;
                    tw_d    = '0;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    push = 1'b1;
                    if (phase_q == PH_LAST) begin
                        state_d = S_BFLY;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_BFLY: begin
                in_ready = 1'b1;
                sel1     = 1'b1;
                sel2     = 1'b1;
                if (in_valid) begin
                    push  = 1'b1;
                    pop   = 1'b1;
                    issue = 1'b1;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        tw_d    = '0;
                        if (blk_q != BLK_LAST) begin
                            state_d = S_DRAIN;
                            blk_d   = blk_q + 1'b1;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                        tw_d    = tw_next;
                    end
                end
            end
            S_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    push  = 1'b1;
                    pop   = 1'b1;
                    issue = 1'b1;
                    if (phase_q == PH_LAST) begin
                        state_d = S_BFLY;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                pop   = 1'b1;
                issue = 1'b1;
                if (phase_q == PH_LAST) begin
                    state_d = S_DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Multiplier latency pipeline for the result-valid flag.
    generate
        if (MUL_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) sr_q <= '0;
                else        sr_q <= issue;
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (!rst_n) sr_q <= '0;
                else        sr_q <= {sr_q[MUL_LAT-2:0], issue};
            end
        end
    endgenerate

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: two instances (unit/double twiddle step, latency 1/2) checked
// every cycle against a frame-position model.
module tb_ntt_stage_ctrl;

    localparam int D   = 4;
    localparam int BL  = 2;
    localparam int TWD = 8;
    localparam int N   = 2 * D * BL;

    logic clk = 1'b0;
    logic rst_n, start, tw_ready, in_valid;

    logic       in_ready_a, push_a, pop_a, sel1_a, sel2_a, out_valid_a, busy_a, done_a;
    logic [2:0] tw_addr_a, state_a;
    logic       in_ready_b, push_b, pop_b, sel1_b, sel2_b, out_valid_b, busy_b, done_b;
    logic [2:0] tw_addr_b, state_b;

    always #5 clk = ~clk;

    ntt_stage_ctrl #(.FIFO_DEPTH(D), .BLOCKS(BL), .TW_DEPTH(TWD), .TW_STEP(1), .MUL_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .tw_ready(tw_ready), .in_valid(in_valid),
        .in_ready(in_ready_a), .push(push_a), .pop(pop_a), .sel1(sel1_a), .sel2(sel2_a),
        .tw_addr(tw_addr_a), .out_valid(out_valid_a), .busy(busy_a), .done(done_a), .state(state_a)
    );

    ntt_stage_ctrl #(.FIFO_DEPTH(D), .BLOCKS(BL), .TW_DEPTH(TWD), .TW_STEP(2), .MUL_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .tw_ready(tw_ready), .in_valid(in_valid),
        .in_ready(in_ready_b), .push(push_b), .pop(pop_b), .sel1(sel1_b), .sel2(sel2_b),
        .tw_addr(tw_addr_b), .out_valid(out_valid_b), .busy(busy_b), .done(done_b), .state(state_b)
    );

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 streaming (k samples accepted), 2 flushing (f cycles), 3 done.
    int         mode = 0;
    int         k = 0;
    int         f = 0;
    logic [7:0] hist = '0;
    int ov_a = 0, ov_b = 0, dn_a = 0, dn_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check both DUTs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        int seg, ph, e_st, e_twa, e_twb;
        logic e_inr, e_push, e_pop, e_sel, e_done, e_issue;
        seg = k / D;
        ph  = k % D;
        e_st = 0; e_twa = 0; e_twb = 0;
        e_inr = 0; e_push = 0; e_pop = 0; e_sel = 0; e_done = 0;
        case (mode)
            1: begin
                e_st   = (seg == 0) ? 1 : ((seg % 2 == 1) ? 2 : 3);
                e_inr  = 1;
                e_push = in_valid;
                e_pop  = in_valid && (seg > 0);
                e_sel  = (seg % 2 == 1);
                if (e_sel) begin
                    e_twa = (ph * 1) % TWD;
                    e_twb = (ph * 2) % TWD;
                end
            end
            2: begin e_st = 4; e_pop = 1; end
            3: begin e_st = 5; e_done = 1; end
            default: ;
        endcase
        e_issue = e_pop;
        @(negedge clk);
        chk("state_a", 32'(state_a), e_st);          chk("state_b", 32'(state_b), e_st);
        chk("in_ready_a", 32'(in_ready_a), 32'(e_inr)); chk("in_ready_b", 32'(in_ready_b), 32'(e_inr));
        chk("push_a", 32'(push_a), 32'(e_push));     chk("push_b", 32'(push_b), 32'(e_push));
        chk("pop_a", 32'(pop_a), 32'(e_pop));        chk("pop_b", 32'(pop_b), 32'(e_pop));
        chk("sel1_a", 32'(sel1_a), 32'(e_sel));      chk("sel1_b", 32'(sel1_b), 32'(e_sel));
        chk("sel2_a", 32'(sel2_a), 32'(e_sel));      chk("sel2_b", 32'(sel2_b), 32'(e_sel));
        chk("tw_addr_a", 32'(tw_addr_a), e_twa);     chk("tw_addr_b", 32'(tw_addr_b), e_twb);
        chk("busy_a", 32'(busy_a), 32'(mode != 0));  chk("busy_b", 32'(busy_b), 32'(mode != 0));
        chk("done_a", 32'(done_a), 32'(e_done));     chk("done_b", 32'(done_b), 32'(e_done));
        chk("out_valid_a", 32'(out_valid_a), 32'(hist[0]));
        chk("out_valid_b", 32'(out_valid_b), 32'(hist[1]));
        if (out_valid_a === 1'b1) ov_a++;
        if (out_valid_b === 1'b1) ov_b++;
        if (done_a === 1'b1) dn_a++;
        if (done_b === 1'b1) dn_b++;
        @(posedge clk);
        if (!rst_n) begin
            mode = 0; k = 0; f = 0; hist = '0;
        end else begin
            hist = {hist[6:0], e_issue};
            case (mode)
                0: if (start && tw_ready) begin mode = 1; k = 0; end
                1: if (in_valid) begin
                       k++;
                       if (k == N) begin mode = 2; f = 0; end
                   end
                2: begin f++; if (f == D) mode = 3; end
                default: mode = 0;
            endcase
        end
        #1;
    endtask

    task automatic clear_counts();
        ov_a = 0; ov_b = 0; dn_a = 0; dn_b = 0;
    endtask

    // Run to the end of a frame with bounded cycles, then let trailing valids out.
    task automatic finish_frame(input int valid_pct, input bit noise);
        int n = 0;
        while (mode != 0 && n < 300) begin
            in_valid = ($urandom_range(99) < valid_pct);
            start    = noise ? 1'($urandom % 2) : 1'b0;
            tw_ready = noise ? 1'($urandom % 2) : 1'b1;
            cyc();
            n++;
        end
        chk("frame_timeout", 32'(n < 300), 1);
        start = 0; in_valid = 0; tw_ready = 1;
        repeat (4) cyc();
        chk("ov_count_a", ov_a, N); chk("ov_count_b", ov_b, N);
        chk("done_count_a", dn_a, 1); chk("done_count_b", dn_b, 1);
    endtask

    task automatic begin_frame();
        clear_counts();
        start = 1; tw_ready = 1; in_valid = 1;
        cyc();
        start = 0;
    endtask

    initial begin
        rst_n = 0; start = 0; tw_ready = 0; in_valid = 0;
        @(posedge clk); #1;
        repeat (2) cyc();
        rst_n = 1;
        cyc();

        // start without loaded twiddles is ignored
        start = 1; tw_ready = 0; in_valid = 1;
        repeat (3) cyc();
        start = 0;
        cyc();

        // nominal back-to-back stream
        begin_frame();
        finish_frame(100, 1'b0);

        // three-cycle stall at BFLY phase 2
        begin_frame();
        repeat (6) cyc();
        in_valid = 0;
        repeat (3) begin
            cyc();
            chk("stall_tw_a", 32'(tw_addr_a), 2);
            chk("stall_tw_b", 32'(tw_addr_b), 4);
        end
        finish_frame(100, 1'b0);

        // reset in DRAIN aborts the frame without done
        begin_frame();
        repeat (10) cyc();
        chk("in_drain", 32'(state_a), 3);
        rst_n = 0;
        cyc();
        rst_n = 1;
        repeat (4) cyc();
        chk("abort_done_a", dn_a, 0); chk("abort_done_b", dn_b, 0);

        // fresh frames with random stalls and spurious start pulses
        repeat (4) begin
            begin_frame();
            finish_frame(40 + int'($urandom_range(60)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: stage half-span D, the depth of the feedback FIFO.
REQ-002 SHALL have parameter BLOCKS, default 2: butterfly blocks per frame; frame length N = 2*D*BLOCKS.
REQ-003 SHALL have parameter TW_DEPTH, default 8: twiddle RAM depth.
REQ-004 SHALL have parameter TW_STEP, default 1: twiddle address increment per butterfly cycle.
REQ-005 SHALL have parameter MUL_LAT, default 1: Montgomery multiplier latency in cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit: frame start request.
REQ-009 SHALL have port tw_ready, input, 1 bit: twiddle RAM loaded (full_ram).
REQ-010 SHALL have port in_valid, input, 1 bit: an input sample is present.
REQ-011 SHALL have port in_ready, output, 1 bit: the stage accepts an input sample this cycle.
REQ-012 SHALL have ports push and pop, output, 1 bit each: FIFO write and read strobes.
REQ-013 SHALL have ports sel1 and sel2, output, 1 bit each: feedback-mux select and output-mux select.
REQ-014 SHALL have port tw_addr, output, clog2(TW_DEPTH) bits: twiddle RAM read address.
REQ-015 SHALL have port out_valid, output, 1 bit: the multiplier result is valid this cycle.
REQ-016 SHALL have ports busy and done, output, 1 bit each: frame in progress, and a one-cycle frame-complete pulse.
REQ-017 SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-018 SHALL implement the FSM states IDLE=0, FILL=1, BFLY=2, DRAIN=3, FLUSH=4 and DONE=5.
REQ-019 SHALL move IDLE->FILL only when start=1 and tw_ready=1; otherwise start is ignored, including when start arrives while busy.
REQ-020 SHALL keep a phase counter 0..D-1 and a block counter 0..BLOCKS-1; the phase counter wraps to 0 on every state change.
REQ-021 FILL SHALL drive push=1, pop=0, sel1=0 and sel2=0 per accepted sample, and SHALL move to BFLY after D accepted samples.
REQ-022 BFLY SHALL drive push=1, pop=1, sel1=1 and sel2=1 per accepted sample: the butterfly difference feeds back into the FIFO and the sum goes to the multiplier.
REQ-023 BFLY SHALL move after D accepted samples to DRAIN if block_cnt<BLOCKS-1 (block_cnt+1), else to FLUSH.
REQ-024 DRAIN SHALL drive push=1, pop=1, sel1=0 and sel2=0 per accepted sample (stored differences out, new inputs in), and SHALL move to BFLY after D accepted samples.
REQ-025 FLUSH SHALL drive in_ready=0, push=0, pop=1, sel2=0 and sel1=0 for D cycles unconditionally, then move to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-027 in_ready SHALL be 1 in FILL, BFLY and DRAIN and 0 in every other state.
REQ-028 SHALL stall when in_valid=0 in FILL, BFLY or DRAIN: push=pop=0, all counters and tw_addr hold, state holds.
REQ-029 tw_addr SHALL be 0 on the first BFLY cycle of each block, advance by TW_STEP modulo TW_DEPTH per accepted BFLY sample, and hold 0 in all other states.
REQ-030 SHALL form a multiplier-issue strobe = (pop in BFLY, DRAIN or FLUSH) and delay it MUL_LAT cycles through a shift register to give out_valid.
REQ-031 out_valid SHALL assert exactly N times per frame; trailing out_valid from the FLUSH pipeline SHALL still be emitted after done.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 In IDLE and DONE, push, pop, sel1 and sel2 SHALL all be 0.

Reset
REQ-034 When rst_n=0 at a clock edge, SHALL force state=IDLE, clear both counters, tw_addr, the out_valid pipeline and every strobe to 0, and drive in_ready=0, busy=0 and done=0.
REQ-035 A reset asserted mid-frame SHALL abort the frame with no done pulse; the next frame SHALL need a fresh start.

Verification
REQ-036 D=4, BLOCKS=2, in_valid=1 continuously, start=1 with tw_ready=1 -> FILL 4, BFLY 4, DRAIN 4, BFLY 4, FLUSH 4, then done=1 for 1 cycle; 16 out_valid pulses, the last one MUL_LAT cycles after FLUSH ends.
REQ-037 start with tw_ready=0 -> remain in IDLE, busy=0, push=pop=0.
REQ-038 in_valid dropped for 3 cycles at BFLY phase 2 -> push=pop=0 and tw_addr holds at 2 for those 3 cycles; the frame finishes 3 cycles late with 16 out_valid pulses.
REQ-039 TW_STEP=2, TW_DEPTH=8 -> tw_addr goes 0,2,4,6 in each BFLY block and reads 0 in FILL and DRAIN.
REQ-040 rst_n=0 during DRAIN -> the next edge shows state=0, all outputs 0, no done pulse; a new start gives a normal 16-sample frame.
REQ-041 start pulsed again during BFLY -> ignored; the frame timing is unchanged.
